// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
package fifo_rd_packer_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_PACK_RATIO = 4;

  typedef enum logic {FILL, HOLD} pack_state_e;

  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_packer_sva.sv
// Protocol assertions for fifo_rd_packer, attached to every instance by bind.
module fifo_rd_packer_sva #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned PACK_RATIO = 4
) (
  input logic                             clk,
  input logic                             rst_n,
  input logic                             fifo_empty,
  input logic                             fifo_rd_en,
  input logic                             pack_valid,
  input logic                             pack_ready,
  input logic [PACK_RATIO*FIFO_WIDTH-1:0] pack_data,
  input logic [PACK_RATIO-1:0]            pack_keep
);

  a_no_rd_when_empty: assert property (
    @(posedge clk) disable iff (!rst_n) fifo_empty |-> !fifo_rd_en);

  a_hold_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (pack_valid && !pack_ready) |=> (pack_valid && $stable(pack_data) && $stable(pack_keep)));

endmodule

bind fifo_rd_packer fifo_rd_packer_sva #(
  .FIFO_WIDTH(FIFO_WIDTH),
  .PACK_RATIO(PACK_RATIO)
) u_sva (
  .clk       (clk),
  .rst_n     (rst_n),
  .fifo_empty(fifo_empty),
  .fifo_rd_en(fifo_rd_en),
  .pack_valid(pack_valid),
  .pack_ready(pack_ready),
  .pack_data (pack_data),
  .pack_keep (pack_keep)
);

// File: rtl/fifo_rd_packer.sv
// Drains a synchronous FIFO and packs PACK_RATIO words into one valid/ready beat.
// Optional partial-beat flush is enabled by defining PACK_FLUSH_EN.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned PACK_RATIO = DEF_PACK_RATIO,
  parameter int unsigned CNT_W      = $clog2(PACK_RATIO + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  input  logic                             pack_ready,
  output logic                             pack_valid,
  output logic [PACK_RATIO*FIFO_WIDTH-1:0] pack_data,
  output logic [PACK_RATIO-1:0]            pack_keep
);

  localparam int unsigned SUM_W = CNT_W + 1;

  pack_state_e                           state_q, state_d;
  logic [CNT_W-1:0]                      lane_cnt_q, lane_cnt_d;
  logic                                  rd_pend_q, rd_pend_d;
  logic                                  pack_valid_q, pack_valid_d;
  logic [PACK_RATIO-1:0]                 pack_keep_q, pack_keep_d;
  logic [PACK_RATIO-1:0][FIFO_WIDTH-1:0] lanes_q, lanes_d;
  logic                                  rd_en_c;

`ifdef PACK_FLUSH_EN
  logic                  flush_hold_q, flush_hold_d;
  logic [PACK_RATIO-1:0] part_keep_c;

  // Lanes [lane_cnt-1:0] are the ones holding captured words.
  always_comb begin
    part_keep_c = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      part_keep_c[i] = (CNT_W'(i) < lane_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_hold_q <= 1'b0;
    end else begin
      flush_hold_q <= flush_hold_d;
    end
  end
`else
  logic flush_hold_q;
  logic unused_flush;

  assign flush_hold_q = 1'b0;
  assign unused_flush = flush;
`endif

  // Room is counted including the word already in flight from the FIFO.
  assign rd_en_c = !fifo_empty && (state_q == FILL) && !flush_hold_q &&
                   ((SUM_W'(lane_cnt_q) + SUM_W'(rd_pend_q)) < SUM_W'(PACK_RATIO));

  assign fifo_rd_en = rd_en_c && rst_n;

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    rd_pend_d    = rd_en_c;
    pack_valid_d = pack_valid_q;
    pack_keep_d  = pack_keep_q;
    lanes_d      = lanes_q;
`ifdef PACK_FLUSH_EN
    flush_hold_d = flush_hold_q | flush;
`endif

    case (state_q)
      FILL: begin
        if (rd_pend_q) begin
          for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (lane_cnt_q == CNT_W'(i)) begin
              lanes_d[i] = fifo_data_out;
            end
          end
          lane_cnt_d = lane_cnt_q + CNT_W'(1);
          if (lane_cnt_d == CNT_W'(PACK_RATIO)) begin
            state_d      = HOLD;
            pack_valid_d = 1'b1;
            pack_keep_d  = '1;
          end
`ifdef PACK_FLUSH_EN
        end else if (flush_hold_q) begin
          // Flush resolves only once no read word is still in flight.
          if (lane_cnt_q != '0) begin
            state_d      = HOLD;
            pack_valid_d = 1'b1;
            pack_keep_d  = part_keep_c;
          end
          flush_hold_d = flush;
`endif
        end
      end
      HOLD: begin
        if (pack_ready) begin
          state_d      = FILL;
          pack_valid_d = 1'b0;
          lane_cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      pack_valid_q <= 1'b0;
      pack_keep_q  <= '0;
      lanes_q      <= '0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      rd_pend_q    <= rd_pend_d;
      pack_valid_q <= pack_valid_d;
      pack_keep_q  <= pack_keep_d;
      lanes_q      <= lanes_d;
    end
  end

  assign pack_valid = pack_valid_q;
  assign pack_keep  = pack_keep_q;
  assign pack_data  = lanes_q;

endmodule
